int_arbiter: RTL and testbench

- Interrupt request arbiter. Sits directly upstream of the interrupt vector decoder.
- Captures rising edges on four interrupt source lines and applies a per-source mask and a global enable.
- Picks the highest-priority eligible source and presents its 2-bit code plus a request to the CPU control unit.
- Tracks in-service levels across acknowledge and return-from-interrupt, so only higher-priority sources can nest.
- out_code drives the vector decoder's 2-bit code input directly.

---
 rtl/int_arbiter.sv | 125 ++++++++++++
 tb/tb_int_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/int_arbiter.sv
// Interrupt request arbiter: edge-captures four sources, masks them, and presents the
// highest-priority eligible code to the CPU. Nesting of higher-priority sources is enabled by INT_NEST_EN.
module int_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int CODE_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] in_irq,
  input  logic               in_mask_we,
  input  logic [NUM_SRC-1:0] in_mask_data,
  input  logic               in_ie,
  input  logic               in_ack,
  input  logic               in_eret,
  output logic               out_int,
  output logic [CODE_W-1:0]  out_code,
  output logic [NUM_SRC-1:0] out_pending,
  output logic [NUM_SRC-1:0] out_isr
);

  localparam int LVL_W = CODE_W + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_SRC-1:0]  pending_q, pending_d;
  logic [NUM_SRC-1:0]  mask_q, mask_d;
  logic [NUM_SRC-1:0]  isr_q, isr_d;
  logic [NUM_SRC-1:0]  irq_prev_q, irq_prev_d;
  logic [CODE_W-1:0]   code_q, code_d;

  logic [NUM_SRC-1:0]  rise;
  logic [NUM_SRC-1:0]  eligible;
  logic [NUM_SRC-1:0]  eret_clear;
  logic [LVL_W-1:0]    cur_level;
  logic [CODE_W-1:0]   sel_code;
  logic                sel_valid;

  // Current service level is the lowest-numbered in-service source, NUM_SRC when idle.
  always_comb begin
    rise      = in_irq & ~irq_prev_q;
    cur_level = LVL_W'(NUM_SRC);
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (isr_q[i]) cur_level = LVL_W'(i);
    end
    eligible = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
`ifdef INT_NEST_EN
      eligible[i] = pending_q[i] & ~mask_q[i] & (LVL_W'(i) < cur_level);
`else
      eligible[i] = pending_q[i] & ~mask_q[i] & (LVL_W'(i) < cur_level) & (isr_q == '0);
`endif
    end
    sel_code  = '0;
    sel_valid = |eligible;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel_code = CODE_W'(i);
    end
`ifdef INT_NEST_EN
    eret_clear = isr_q & (~isr_q + NUM_SRC'(1));
`else
    eret_clear = '1;
`endif
  end

  // Eret is applied to the pre-ack isr value so an ack in the same cycle still lands its bit.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    pending_d  = pending_q;
    isr_d      = isr_q;
    mask_d     = in_mask_we ? in_mask_data : mask_q;
    irq_prev_d = in_irq;

    if (in_eret) isr_d = isr_q & ~eret_clear;

    case (state_q)
      IDLE: begin
        if (in_ie && sel_valid) begin
          code_d  = sel_code;
          state_d = REQ;
        end
      end
      REQ: begin
        if (in_ack) begin
          isr_d[code_q]     = 1'b1;
          pending_d[code_q] = 1'b0;
          state_d           = IDLE;
        end else if (!in_ie || !eligible[code_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    pending_d = pending_d | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      mask_q     <= '0;
      isr_q      <= '0;
      irq_prev_q <= '0;
      code_q     <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      isr_q      <= isr_d;
      irq_prev_q <= irq_prev_d;
      code_q     <= code_d;
    end
  end

  assign out_int     = (state_q == REQ);
  assign out_code    = code_q;
  assign out_pending = pending_q;
  assign out_isr     = isr_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter: directed scenarios plus randomized traffic against a
// per-source behavioural model of pending/mask/in-service bookkeeping.
module tb_int_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] in_irq;
  logic       in_mask_we;
  logic [3:0] in_mask_data;
  logic       in_ie;
  logic       in_ack;
  logic       in_eret;
  logic       out_int;
  logic [1:0] out_code;
  logic [3:0] out_pending;
  logic [3:0] out_isr;

  int checkCount = 0;
  int passCount  = 0;

  int m_pend[4];
  int m_mask[4];
  int m_isr[4];
  int m_prev[4];
  int m_req;
  int m_code;

  int_arbiter #(.NUM_SRC(4), .CODE_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_irq       (in_irq),
    .in_mask_we   (in_mask_we),
    .in_mask_data (in_mask_data),
    .in_ie        (in_ie),
    .in_ack       (in_ack),
    .in_eret      (in_eret),
    .out_int      (out_int),
    .out_code     (out_code),
    .out_pending  (out_pending),
    .out_isr      (out_isr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checkCount++;
    if (got == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int packPend();
    int v = 0;
    for (int i = 0; i < 4; i++) if (m_pend[i] != 0) v += (1 << i);
    return v;
  endfunction

  function automatic int packIsr();
    int v = 0;
    for (int i = 0; i < 4; i++) if (m_isr[i] != 0) v += (1 << i);
    return v;
  endfunction

  // Reference: the highest-priority source in service sets the level; only strictly
  // more urgent, unmasked, pending sources may be offered to the CPU.
  task automatic modelStep(input int r, input int irq, input int mwe, input int mdata,
                           input int ie, input int ack, input int eret);
    int level;
    int anyIsr;
    int first;
    int elig[4];
    int nPend[4];
    int nIsr[4];
    if (r != 0) begin
      for (int i = 0; i < 4; i++) begin
        m_pend[i] = 0; m_mask[i] = 0; m_isr[i] = 0; m_prev[i] = 0;
      end
      m_req  = 0;
      m_code = 0;
      return;
    end
    level  = 4;
    anyIsr = 0;
    for (int i = 3; i >= 0; i--) if (m_isr[i] != 0) begin level = i; anyIsr = 1; end
    first = -1;
    for (int i = 0; i < 4; i++) begin
      elig[i] = (m_pend[i] != 0 && m_mask[i] == 0 && i < level) ? 1 : 0;
`ifndef INT_NEST_EN
      if (anyIsr != 0) elig[i] = 0;
`endif
      if (elig[i] != 0 && first < 0) first = i;
      nPend[i] = m_pend[i];
      nIsr[i]  = m_isr[i];
    end
    if (eret != 0 && anyIsr != 0) begin
`ifdef INT_NEST_EN
      nIsr[level] = 0;
`else
      for (int i = 0; i < 4; i++) nIsr[i] = 0;
`endif
    end
    if (m_req == 0) begin
      if (ie != 0 && first >= 0) begin
        m_req  = 1;
        m_code = first;
      end
    end else if (ack != 0) begin
      nIsr[m_code]  = 1;
      nPend[m_code] = 0;
      m_req         = 0;
    end else if (ie == 0 || elig[m_code] == 0) begin
      m_req = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (((irq >> i) & 1) != 0 && m_prev[i] == 0) nPend[i] = 1;
      m_prev[i] = (irq >> i) & 1;
      if (mwe != 0) m_mask[i] = (mdata >> i) & 1;
      m_pend[i] = nPend[i];
      m_isr[i]  = nIsr[i];
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the rising edge,
  // then compare every output against the model at the next falling edge.
  task automatic applyStimulus(input int r, input int irq, input int mwe, input int mdata,
                               input int ie, input int ack, input int eret);
    rst          = r[0];
    in_irq       = irq[3:0];
    in_mask_we   = mwe[0];
    in_mask_data = mdata[3:0];
    in_ie        = ie[0];
    in_ack       = ack[0];
    in_eret      = eret[0];
    @(posedge clk);
    modelStep(r, irq, mwe, mdata, ie, ack, eret);
    @(negedge clk);
    checkOutput("out_int", int'(out_int), m_req);
    checkOutput("out_pending", int'(out_pending), packPend());
    checkOutput("out_isr", int'(out_isr), packIsr());
    if (m_req != 0) checkOutput("out_code", int'(out_code), m_code);
  endtask

  initial begin
    rst = 1'b1; in_irq = 4'b0; in_mask_we = 1'b0; in_mask_data = 4'b0;
    in_ie = 1'b0; in_ack = 1'b0; in_eret = 1'b0;
    m_req = 0; m_code = 0;
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 0; m_mask[i] = 0; m_isr[i] = 0; m_prev[i] = 0;
    end
    @(negedge clk);

    applyStimulus(1, 4'b1111, 0, 0, 0, 0, 0);
    applyStimulus(1, 4'b1111, 0, 0, 0, 0, 0);
    checkOutput("reset_int", int'(out_int), 0);
    checkOutput("reset_code", int'(out_code), 0);
    checkOutput("reset_pending", int'(out_pending), 0);
    checkOutput("reset_isr", int'(out_isr), 0);
    applyStimulus(0, 4'b0000, 0, 0, 1, 0, 0);

    // Single source 2 through ack and eret
    applyStimulus(0, 4'b0100, 0, 0, 1, 0, 0);
    checkOutput("src2_pending", int'(out_pending), 4);
    checkOutput("src2_int_early", int'(out_int), 0);
    applyStimulus(0, 4'b0100, 0, 0, 1, 0, 0);
    checkOutput("src2_int", int'(out_int), 1);
    checkOutput("src2_code", int'(out_code), 2);
    applyStimulus(0, 4'b0100, 0, 0, 1, 1, 0);
    checkOutput("src2_ack_isr", int'(out_isr), 4);
    checkOutput("src2_ack_pending", int'(out_pending), 0);
    checkOutput("src2_ack_int", int'(out_int), 0);
    applyStimulus(0, 4'b0000, 0, 0, 1, 0, 1);
    checkOutput("src2_eret_isr", int'(out_isr), 0);

    // Sources 1 and 3 together: 1 first, 3 only after eret
    applyStimulus(0, 4'b1010, 0, 0, 1, 0, 0);
    applyStimulus(0, 4'b1010, 0, 0, 1, 0, 0);
    checkOutput("pair_code_first", int'(out_code), 1);
    applyStimulus(0, 4'b1010, 0, 0, 1, 1, 0);
    applyStimulus(0, 4'b1010, 0, 0, 1, 0, 0);
    applyStimulus(0, 4'b1010, 0, 0, 1, 0, 0);
    checkOutput("pair_src3_blocked", int'(out_int), 0);
    applyStimulus(0, 4'b1010, 0, 0, 1, 0, 1);
    checkOutput("pair_after_eret_int", int'(out_int), 0);
    applyStimulus(0, 4'b1010, 0, 0, 1, 0, 0);
    checkOutput("pair_src3_int", int'(out_int), 1);
    checkOutput("pair_src3_code", int'(out_code), 3);
    applyStimulus(0, 4'b0000, 0, 0, 1, 1, 0);
    applyStimulus(0, 4'b0000, 0, 0, 1, 0, 1);

    // Withdraw by masking, then unmask, then ack coinciding with a new rise
    applyStimulus(0, 4'b0010, 0, 0, 1, 0, 0);
    applyStimulus(0, 4'b0010, 0, 0, 1, 0, 0);
    checkOutput("wd_code", int'(out_code), 1);
    applyStimulus(0, 4'b0010, 1, 4'b0010, 1, 0, 0);
    applyStimulus(0, 4'b0010, 0, 0, 1, 0, 0);
    checkOutput("wd_int", int'(out_int), 0);
    checkOutput("wd_pending", int'(out_pending), 2);
    applyStimulus(0, 4'b0010, 1, 4'b0000, 1, 0, 0);
    applyStimulus(0, 4'b0010, 0, 0, 1, 0, 0);
    checkOutput("unmask_int", int'(out_int), 1);
    applyStimulus(0, 4'b0000, 0, 0, 1, 0, 0);
    applyStimulus(0, 4'b0010, 0, 0, 1, 1, 0);
    checkOutput("ackrise_isr", int'(out_isr), 2);
    checkOutput("ackrise_pending", int'(out_pending), 2);
    applyStimulus(0, 4'b0000, 0, 0, 1, 0, 1);
    applyStimulus(0, 4'b0000, 0, 0, 1, 0, 0);
    applyStimulus(0, 4'b0000, 0, 0, 1, 1, 0);
    applyStimulus(0, 4'b0000, 0, 0, 1, 0, 1);

    // Source 0 arriving while source 2 is in service
    applyStimulus(0, 4'b0100, 0, 0, 1, 0, 0);
    applyStimulus(0, 4'b0100, 0, 0, 1, 0, 0);
    applyStimulus(0, 4'b0100, 0, 0, 1, 1, 0);
    applyStimulus(0, 4'b0101, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 4'b0101, 0, 0, 1, 1, 0);
    applyStimulus(0, 4'b0000, 0, 0, 1, 0, 1);
    for (int k = 0; k < 3; k++) applyStimulus(0, 4'b0000, 0, 0, 1, 1, 0);
    applyStimulus(0, 4'b0000, 0, 0, 1, 0, 1);
    applyStimulus(0, 4'b0000, 0, 0, 1, 0, 1);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom_range(0, 99) == 0) ? 1 : 0,
                    int'($urandom_range(0, 15)),
                    ($urandom_range(0, 7) == 0) ? 1 : 0,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0,
                    ($urandom_range(0, 9) == 0) ? 0 : 1,
                    int'($urandom_range(0, 1)),
                    ($urandom_range(0, 5) == 0) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
